// File: rtl/jt900h_pcu.sv
// Program-counter unit for the JT900H core: byte advance, absolute jump,
// relative branch and a circular hardware return-address stack.
module jt900h_pcu #(
  parameter int          AW     = 32,
  parameter int          ADVW   = 3,
  parameter int          RSD    = 4,
  parameter logic [AW-1:0] RST_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic [ADVW-1:0]        adv_len,
  input  logic                   jmp_en,
  input  logic [AW-1:0]          jmp_addr,
  input  logic                   rel_en,
  input  logic [15:0]            rel_off,
  input  logic                   call_en,
  input  logic                   ret_en,
  input  logic                   err_clr,
  output logic [AW-1:0]          pc,
  output logic [AW-1:0]          ret_top,
  output logic [$clog2(RSD):0]   rs_cnt,
  output logic                   rs_empty,
  output logic                   rs_full,
  output logic                   rs_ovf,
  output logic                   rs_unf
);

  localparam int PW = $clog2(RSD);
  localparam int CW = PW + 1;

  logic [AW-1:0] stack [RSD];
  logic [PW-1:0] ptr;
  logic [AW-1:0] pc_r;
  logic [CW-1:0] cnt;
  logic          ovf, unf;

  logic [AW-1:0] nxt, rel_ext, top;
  logic          empty, full;

  logic [AW-1:0] pc_nxt;
  logic [PW-1:0] ptr_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic          ovf_set, unf_set;

  assign nxt     = pc_r + AW'(adv_len);
  assign rel_ext = AW'($signed(rel_off));
  assign top     = stack[ptr];
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(RSD));

  // ptr always addresses the newest entry; a push pre-increments it, so on a
  // full stack the write lands on the oldest entry.
  always_comb begin
    pc_nxt  = nxt;
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    wr_en   = 1'b0;
    wr_idx  = ptr;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ret_en && !empty) begin
      pc_nxt = top;
      if (call_en) begin
        wr_en = 1'b1;
      end else begin
        ptr_nxt = ptr - PW'(1);
        cnt_nxt = cnt - CW'(1);
      end
    end else if (ret_en && !call_en) begin
      pc_nxt  = jmp_addr;
      unf_set = 1'b1;
    end else if (call_en) begin
      pc_nxt  = jmp_addr;
      ptr_nxt = ptr + PW'(1);
      wr_en   = 1'b1;
      wr_idx  = ptr + PW'(1);
      ovf_set = full;
      cnt_nxt = full ? cnt : cnt + CW'(1);
    end else if (jmp_en) begin
      pc_nxt = jmp_addr;
    end else if (rel_en) begin
      pc_nxt = nxt + rel_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RST_PC;
      ptr  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
      for (int i = 0; i < RSD; i++) stack[i] <= '0;
    end else if (cen) begin
      pc_r <= pc_nxt;
      ptr  <= ptr_nxt;
      cnt  <= cnt_nxt;
      ovf  <= (ovf & ~err_clr) | ovf_set;
      unf  <= (unf & ~err_clr) | unf_set;
      if (wr_en) stack[wr_idx] <= nxt;
    end
  end

  assign pc       = pc_r;
  assign ret_top  = empty ? '0 : top;
  assign rs_cnt   = cnt;
  assign rs_empty = empty;
  assign rs_full  = full;
  assign rs_ovf   = ovf;
  assign rs_unf   = unf;

endmodule

// File: tb/tb_jt900h_pcu.sv
// Scoreboard bench for jt900h_pcu: directed vectors push hand-computed
// expected state; a monitor pops and compares one cycle after each edge.
module tb_jt900h_pcu;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] top;
      logic [2:0]  cnt;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst, cen;
   logic [2:0]  advLen;
   logic        jmpEn, relEn, callEn, retEn, errClr;
   logic [31:0] jmpAddr;
   logic [15:0] relOff;
   logic [31:0] pcOut, retTop;
   logic [2:0]  rsCnt;
   logic        rsEmpty, rsFull, rsOvf, rsUnf;

   exp_t expQ[$];
   int   vecCount = 0;
   int   missCount = 0;

   jt900h_pcu #(.AW(32), .ADVW(3), .RSD(4), .RST_PC(32'h0)) dut (
      .clk(clock), .rst(rst), .cen(cen), .adv_len(advLen),
      .jmp_en(jmpEn), .jmp_addr(jmpAddr), .rel_en(relEn), .rel_off(relOff),
      .call_en(callEn), .ret_en(retEn), .err_clr(errClr),
      .pc(pcOut), .ret_top(retTop), .rs_cnt(rsCnt), .rs_empty(rsEmpty),
      .rs_full(rsFull), .rs_ovf(rsOvf), .rs_unf(rsUnf)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Drives one cycle of inputs on the falling edge and queues the state
   // the PCU must show after the following rising edge.
   task automatic applyStimulus(input logic [31:0] ePc, input logic [31:0] eTop,
                                input logic [2:0] eCnt,
                                input logic eOvf = 1'b0, input logic eUnf = 1'b0,
                                input logic r = 1'b0, input logic c = 1'b1,
                                input logic [2:0] adv = 3'd0,
                                input logic j = 1'b0, input logic [31:0] ja = 32'h0,
                                input logic rl = 1'b0, input logic [15:0] off = 16'h0,
                                input logic cl = 1'b0, input logic rt = 1'b0,
                                input logic clr = 1'b0);
      exp_t e;
      @(negedge clock);
      rst = r; cen = c; advLen = adv; jmpEn = j; jmpAddr = ja;
      relEn = rl; relOff = off; callEn = cl; retEn = rt; errClr = clr;
      e.pc = ePc; e.top = eTop; e.cnt = eCnt; e.ovf = eOvf; e.unf = eUnf;
      expQ.push_back(e);
   endtask

   // Compares every observable output against one popped expectation.
   task automatic checkOutput(input exp_t e);
      vecCount++;
      if (pcOut !== e.pc) begin
         missCount++;
         $display("[TB] FAIL vec%0d pc: got %h expected %h", vecCount, pcOut, e.pc);
      end
      if (retTop !== e.top) begin
         missCount++;
         $display("[TB] FAIL vec%0d ret_top: got %h expected %h", vecCount, retTop, e.top);
      end
      if (rsCnt !== e.cnt) begin
         missCount++;
         $display("[TB] FAIL vec%0d rs_cnt: got %0d expected %0d", vecCount, rsCnt, e.cnt);
      end
      if (rsEmpty !== (e.cnt == 3'd0)) begin
         missCount++;
         $display("[TB] FAIL vec%0d rs_empty: got %b expected %b", vecCount, rsEmpty, e.cnt == 3'd0);
      end
      if (rsFull !== (e.cnt == 3'd4)) begin
         missCount++;
         $display("[TB] FAIL vec%0d rs_full: got %b expected %b", vecCount, rsFull, e.cnt == 3'd4);
      end
      if (rsOvf !== e.ovf) begin
         missCount++;
         $display("[TB] FAIL vec%0d rs_ovf: got %b expected %b", vecCount, rsOvf, e.ovf);
      end
      if (rsUnf !== e.unf) begin
         missCount++;
         $display("[TB] FAIL vec%0d rs_unf: got %b expected %b", vecCount, rsUnf, e.unf);
      end
   endtask

   // Monitor: just after each rising edge, the response to the vector driven
   // on the previous falling edge is visible on the outputs.
   always @(posedge clock) begin
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
   end

   // Directed sequence; expected values worked out by hand.
   initial begin
      rst = 1'b1; cen = 1'b0; advLen = '0; jmpEn = 1'b0; jmpAddr = '0;
      relEn = 1'b0; relOff = '0; callEn = 1'b0; retEn = 1'b0; errClr = 1'b0;

      // reset and plain advance
      applyStimulus(.ePc(32'h0), .eTop(32'h0), .eCnt(3'd0), .r(1'b1));
      applyStimulus(.ePc(32'h2), .eTop(32'h0), .eCnt(3'd0), .adv(3'd2));
      applyStimulus(.ePc(32'h5), .eTop(32'h0), .eCnt(3'd0), .adv(3'd3));
      applyStimulus(.ePc(32'h6), .eTop(32'h0), .eCnt(3'd0), .adv(3'd1));
      // wraparound and backward relative branch
      applyStimulus(.ePc(32'hFFFF_FFFE), .eTop(32'h0), .eCnt(3'd0), .j(1'b1), .ja(32'hFFFF_FFFE));
      applyStimulus(.ePc(32'h1), .eTop(32'h0), .eCnt(3'd0), .adv(3'd3));
      applyStimulus(.ePc(32'hFFFF_FFF3), .eTop(32'h0), .eCnt(3'd0), .adv(3'd2), .rl(1'b1), .off(16'hFFF0));
      // nested calls and returns
      applyStimulus(.ePc(32'h100), .eTop(32'h0), .eCnt(3'd0), .j(1'b1), .ja(32'h100));
      applyStimulus(.ePc(32'h200), .eTop(32'h104), .eCnt(3'd1), .adv(3'd4), .cl(1'b1), .ja(32'h200));
      applyStimulus(.ePc(32'h300), .eTop(32'h204), .eCnt(3'd2), .adv(3'd4), .cl(1'b1), .ja(32'h300));
      applyStimulus(.ePc(32'h400), .eTop(32'h304), .eCnt(3'd3), .adv(3'd4), .cl(1'b1), .ja(32'h400));
      applyStimulus(.ePc(32'h304), .eTop(32'h204), .eCnt(3'd2), .rt(1'b1));
      applyStimulus(.ePc(32'h204), .eTop(32'h104), .eCnt(3'd1), .rt(1'b1));
      applyStimulus(.ePc(32'h104), .eTop(32'h0), .eCnt(3'd0), .rt(1'b1));
      // overflow: five calls into a four-deep stack
      applyStimulus(.ePc(32'h1000), .eTop(32'h0), .eCnt(3'd0), .j(1'b1), .ja(32'h1000));
      applyStimulus(.ePc(32'h2000), .eTop(32'h1002), .eCnt(3'd1), .adv(3'd2), .cl(1'b1), .ja(32'h2000));
      applyStimulus(.ePc(32'h3000), .eTop(32'h2002), .eCnt(3'd2), .adv(3'd2), .cl(1'b1), .ja(32'h3000));
      applyStimulus(.ePc(32'h4000), .eTop(32'h3002), .eCnt(3'd3), .adv(3'd2), .cl(1'b1), .ja(32'h4000));
      applyStimulus(.ePc(32'h5000), .eTop(32'h4002), .eCnt(3'd4), .adv(3'd2), .cl(1'b1), .ja(32'h5000));
      applyStimulus(.ePc(32'h6000), .eTop(32'h5002), .eCnt(3'd4), .eOvf(1'b1), .adv(3'd2), .cl(1'b1), .ja(32'h6000));
      // drain: newest first, oldest (0x1002) was overwritten
      applyStimulus(.ePc(32'h5002), .eTop(32'h4002), .eCnt(3'd3), .eOvf(1'b1), .rt(1'b1), .ja(32'h7000));
      applyStimulus(.ePc(32'h4002), .eTop(32'h3002), .eCnt(3'd2), .eOvf(1'b1), .rt(1'b1), .ja(32'h7000));
      applyStimulus(.ePc(32'h3002), .eTop(32'h2002), .eCnt(3'd1), .eOvf(1'b1), .rt(1'b1), .ja(32'h7000));
      applyStimulus(.ePc(32'h2002), .eTop(32'h0), .eCnt(3'd0), .eOvf(1'b1), .rt(1'b1), .ja(32'h7000));
      applyStimulus(.ePc(32'h7000), .eTop(32'h0), .eCnt(3'd0), .eOvf(1'b1), .eUnf(1'b1), .rt(1'b1), .ja(32'h7000));
      applyStimulus(.ePc(32'h7000), .eTop(32'h0), .eCnt(3'd0), .clr(1'b1));
      // set wins over clear in the same cycle
      applyStimulus(.ePc(32'h7100), .eTop(32'h0), .eCnt(3'd0), .eUnf(1'b1), .rt(1'b1), .ja(32'h7100), .clr(1'b1));
      applyStimulus(.ePc(32'h7100), .eTop(32'h0), .eCnt(3'd0), .clr(1'b1));
      // swap (ret+call) on non-empty and empty stack
      applyStimulus(.ePc(32'h100), .eTop(32'h0), .eCnt(3'd0), .j(1'b1), .ja(32'h100));
      applyStimulus(.ePc(32'h500), .eTop(32'h104), .eCnt(3'd1), .adv(3'd4), .cl(1'b1), .ja(32'h500));
      applyStimulus(.ePc(32'h104), .eTop(32'h502), .eCnt(3'd1), .adv(3'd2), .cl(1'b1), .rt(1'b1), .ja(32'h900));
      applyStimulus(.ePc(32'h502), .eTop(32'h0), .eCnt(3'd0), .rt(1'b1));
      applyStimulus(.ePc(32'h500), .eTop(32'h0), .eCnt(3'd0), .j(1'b1), .ja(32'h500));
      applyStimulus(.ePc(32'h900), .eTop(32'h502), .eCnt(3'd1), .adv(3'd2), .cl(1'b1), .rt(1'b1), .ja(32'h900));
      // clock enable low freezes everything
      applyStimulus(.ePc(32'h900), .eTop(32'h502), .eCnt(3'd1), .c(1'b0), .adv(3'd3), .j(1'b1), .cl(1'b1), .ja(32'hAAAA));
      // reset during a call, then resume
      applyStimulus(.ePc(32'h0), .eTop(32'h0), .eCnt(3'd0), .r(1'b1), .adv(3'd2), .cl(1'b1), .ja(32'hBBBB));
      applyStimulus(.ePc(32'h1), .eTop(32'h0), .eCnt(3'd0), .adv(3'd1));

      @(negedge clock);
      rst = 1'b0; cen = 1'b0; jmpEn = 1'b0; callEn = 1'b0; retEn = 1'b0; relEn = 1'b0; errClr = 1'b0;
      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clock);
      if (expQ.size() > 0) begin
         missCount++;
         $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
